// File: rtl/i2c_nios_nios2_qsys_0_cpu_mul_pkg.sv
// Shared definitions for the sequential Nios II multiplier: default width,
// op encodings and the FSM state enum.
package i2c_nios_nios2_qsys_0_cpu_mul_pkg;

  localparam int unsigned MUL_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSS = 2'b10,
    OP_MULXSU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P_LL = 3'd1,
    P_LH = 3'd2,
    P_HL = 3'd3,
    P_HH = 3'd4,
    FIX  = 3'd5,
    DONE = 3'd6
  } state_e;

endpackage

// File: rtl/i2c_nios_nios2_qsys_0_cpu_mul_seq_pp.sv
// Half-width unsigned partial-product multiplier; the FSM state picks
// which operand halves feed the single multiplier.
module i2c_nios_nios2_qsys_0_cpu_mul_seq_pp
  import i2c_nios_nios2_qsys_0_cpu_mul_pkg::*;
#(
  parameter int unsigned DATA_W = MUL_DATA_W
) (
  input  state_e              state,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   product
);

  localparam int unsigned HW = DATA_W / 2;

  logic [HW-1:0] a_sel;
  logic [HW-1:0] b_sel;

  always_comb begin
    a_sel = a[HW-1:0];
    b_sel = b[HW-1:0];
    case (state)
      P_LH: b_sel = b[DATA_W-1:HW];
      P_HL: a_sel = a[DATA_W-1:HW];
      P_HH: begin
        a_sel = a[DATA_W-1:HW];
        b_sel = b[DATA_W-1:HW];
      end
      default: ;
    endcase
    product = DATA_W'(a_sel) * DATA_W'(b_sel);
  end

endmodule

// File: rtl/i2c_nios_nios2_qsys_0_cpu_mul_seq.sv
// Sequential multiplier built from four half-width partial products.
// Define MUL_HIGH_EN to enable MULXUU/MULXSS/MULXSU (high-word) operations.
module i2c_nios_nios2_qsys_0_cpu_mul_seq
  import i2c_nios_nios2_qsys_0_cpu_mul_pkg::*;
#(
  parameter int unsigned DATA_W = MUL_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic [1:0]        op,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned HW = DATA_W / 2;
  localparam int unsigned AW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] pp;
  logic [AW-1:0]     pp_ext;

`ifdef MUL_HIGH_EN
  op_e               op_q, op_d;
  logic [DATA_W-1:0] fix_hi;
`else
  logic              op_unused;
  assign op_unused = ^op;
`endif

  i2c_nios_nios2_qsys_0_cpu_mul_seq_pp #(
    .DATA_W (DATA_W)
  ) u_pp (
    .state   (state_q),
    .a       (a_q),
    .b       (b_q),
    .product (pp)
  );

  assign pp_ext = AW'(pp);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
`ifdef MUL_HIGH_EN
    op_d     = op_q;
    // Two's-complement correction of the unsigned high word for signed operands.
    fix_hi   = acc_q[AW-1:DATA_W]
             - ((((op_q == OP_MULXSS) || (op_q == OP_MULXSU)) && a_q[DATA_W-1]) ? b_q : '0)
             - (((op_q == OP_MULXSS) && b_q[DATA_W-1]) ? a_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = E_src1;
          b_d     = E_src2;
          acc_d   = '0;
          state_d = P_LL;
`ifdef MUL_HIGH_EN
          op_d    = op_e'(op);
`endif
        end
      end
      P_LL: begin
        acc_d   = acc_q + pp_ext;
        state_d = P_LH;
      end
      P_LH: begin
        acc_d   = acc_q + (pp_ext << HW);
        state_d = P_HL;
      end
      P_HL: begin
        acc_d = acc_q + (pp_ext << HW);
`ifdef MUL_HIGH_EN
        if (op_q == OP_MUL) begin
          state_d  = DONE;
          result_d = acc_d[DATA_W-1:0];
        end else begin
          state_d  = P_HH;
        end
`else
        state_d  = DONE;
        result_d = acc_d[DATA_W-1:0];
`endif
      end
`ifdef MUL_HIGH_EN
      P_HH: begin
        acc_d   = acc_q + (pp_ext << DATA_W);
        state_d = FIX;
      end
      FIX: begin
        acc_d    = {fix_hi, acc_q[DATA_W-1:0]};
        result_d = fix_hi;
        state_d  = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
`ifdef MUL_HIGH_EN
      op_q     <= OP_MUL;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
`ifdef MUL_HIGH_EN
      op_q     <= op_d;
`endif
    end
  end

  // Result is loaded on entry to DONE so it is valid alongside the done pulse.
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/i2c_nios_nios2_qsys_0_cpu_mul_seq.md
I2C_NIOS_NIOS2_QSYS_0_CPU_MUL_SEQ -- requirements
Module: i2c_nios_nios2_qsys_0_cpu_mul_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; half-width partial products are DATA_W/2.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port E_src1  input  DATA_W  multiplicand A, sampled on accepted start.
REQ-005 SHALL have port E_src2  input  DATA_W  multiplier B, sampled on accepted start.
REQ-006 SHALL have port op  input  2  operation: 00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU (A signed, B unsigned); sampled on accepted start.
REQ-007 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 SHALL have port result  output  DATA_W  last completed result, held until next done.

Function
REQ-011 SHALL use one DATA_W/2 x DATA_W/2 unsigned multiply per cycle; partial products LL=Alo*Blo, LH=Alo*Bhi, HL=Ahi*Blo, HH=Ahi*Bhi.
REQ-012 SHALL use FSM states IDLE, P_LL, P_LH, P_HL, P_HH, FIX, DONE.
REQ-013 SHALL, on start in IDLE, register A, B, op and go to P_LL; 2*DATA_W-bit accumulator cleared.
REQ-014 SHALL add LL at bit 0, LH and HL at bit DATA_W/2, HH at bit DATA_W into the accumulator on exit from the matching state; accumulator arithmetic is modulo 2^(2*DATA_W).
REQ-015 SHALL, for MUL, sequence P_LL->P_LH->P_HL->DONE, skip HH, and produce result = accumulator[DATA_W-1:0]; done occurs 4 cycles after the start cycle.
REQ-016 SHALL, for high ops, sequence P_LL->P_LH->P_HL->P_HH->FIX->DONE; done occurs 6 cycles after the start cycle.
REQ-017 SHALL, in FIX, subtract B from the high word when A is treated as signed and A[DATA_W-1]=1, and subtract A when B is treated as signed and B[DATA_W-1]=1 (MULXSS: both; MULXSU: A only; MULXUU: neither).
REQ-018 SHALL, in DONE, load result from the low (MUL) or high (other ops) accumulator word, assert done, then return to IDLE.
REQ-019 SHALL ignore start while busy=1, including in DONE; operands and result SHALL remain unaffected.
REQ-020 SHALL accept start in the cycle immediately after DONE (back-to-back operation).

Reset
REQ-021 SHALL, on reset assertion at any time including mid-operation, immediately force state IDLE, busy=0, done=0, result=0, and clear the accumulator and operand registers.
REQ-022 SHALL ignore start while reset is high; the first start is accepted on the first edge after deassertion.

Configuration
REQ-023 SHALL honour macro MUL_HIGH_EN: when defined, REQ-016/REQ-017 apply.
REQ-024 SHALL, without MUL_HIGH_EN, omit P_HH, FIX and the correction logic, and treat every op as MUL (4-cycle latency, low word).

Structure
REQ-025 SHALL take op encodings, FSM state enum and DATA_W default from shared package i2c_nios_nios2_qsys_0_cpu_mul_pkg.
REQ-026 SHALL place the half-width unsigned multiply in sub-module i2c_nios_nios2_qsys_0_cpu_mul_seq_pp (combinational, operand select driven by state).

Verification
REQ-027 SHALL verify MUL: A=0x00010003, B=0x00020005 -> result 0x000B000F, done 4 cycles after start.
REQ-028 SHALL verify MULXUU (MUL_HIGH_EN): A=B=0xFFFFFFFF -> result 0xFFFFFFFE, done 6 cycles after start.
REQ-029 SHALL verify MULXSS A=B=0xFFFFFFFF -> 0x00000000; MULXSU A=B=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 SHALL verify start pulsed in P_LH with new operands -> ignored; first result unchanged; exactly one done.
REQ-031 SHALL verify reset asserted in P_HL -> busy=0, done=0, result=0 immediately; next MUL completes correctly.
REQ-032 SHALL verify that without MUL_HIGH_EN, op=01 with A=B=0xFFFFFFFF -> result 0x00000001, done 4 cycles after start.
